// File: rtl/usb_rx_data_buffer.sv
// Receive byte FIFO between the USB receiver and the AHB slave.
// Pops 1/2/4 bytes little-endian into a 32-bit word; sticky error flags.
module usb_rx_data_buffer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int OCC_W  = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             store_rx_packet_data,
  input  logic [7:0]       rx_packet_data,
  input  logic             flush,
  input  logic             get_rx_data,
  input  logic [1:0]       data_size,
  output logic [31:0]      rx_data,
  output logic             rx_data_valid,
  output logic [OCC_W-1:0] buffer_occupancy,
  output logic             rx_overflow,
  output logic             rx_underrun
);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [31:0]       data_q, data_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              und_q, und_d;

  logic [2:0]  pop_n;
  logic        pop_ok, pop_bad;
  logic        st_ok, st_bad;
  logic [7:0]  b0, b1, b2, b3;
  logic [31:0] word;

  // Judge store/pop on pre-edge occupancy and form next state
  always_comb begin
    pop_n = 3'd0;
    unique case (data_size)
      2'd0:    pop_n = 3'd1;
      2'd1:    pop_n = 3'd2;
      2'd2:    pop_n = 3'd4;
      default: pop_n = 3'd0;
    endcase
    pop_ok  = get_rx_data && (data_size != 2'd3)
              && (occ_q >= OCC_W'(pop_n));
    pop_bad = get_rx_data && !pop_ok;
    st_ok   = store_rx_packet_data
              && (occ_q != OCC_W'(DEPTH));
    st_bad  = store_rx_packet_data && !st_ok;

    b0 = mem_q[head_q];
    b1 = mem_q[head_q + ADDR_W'(1)];
    b2 = mem_q[head_q + ADDR_W'(2)];
    b3 = mem_q[head_q + ADDR_W'(3)];
    word = 32'd0;
    unique case (pop_n)
      3'd1:    word = {24'd0, b0};
      3'd2:    word = {16'd0, b1, b0};
      3'd4:    word = {b3, b2, b1, b0};
      default: word = 32'd0;
    endcase

    head_d  = head_q;
    tail_d  = tail_q;
    occ_d   = occ_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ovf_d   = ovf_q;
    und_d   = und_q;

    if (flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
      data_d = 32'd0;
      ovf_d  = 1'b0;
      und_d  = 1'b0;
    end else begin
      if (st_ok)
        tail_d = tail_q + ADDR_W'(1);
      if (pop_ok) begin
        head_d  = head_q + ADDR_W'(pop_n);
        data_d  = word;
        valid_d = 1'b1;
      end
      occ_d = occ_q + OCC_W'(st_ok)
              - (pop_ok ? OCC_W'(pop_n) : '0);
      ovf_d = ovf_q | st_bad;
      und_d = und_q | pop_bad;
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      data_q  <= 32'd0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      und_q   <= und_d;
    end
  end

  // Byte storage; contents are not reset
  always_ff @(posedge clk) begin
    if (!rst && !flush && st_ok)
      mem_q[tail_q] <= rx_packet_data;
  end

  assign rx_data          = data_q;
  assign rx_data_valid    = valid_q;
  assign buffer_occupancy = occ_q;
  assign rx_overflow      = ovf_q;
  assign rx_underrun      = und_q;

endmodule

// File: tb/tb_usb_rx_data_buffer.sv
// Directed bench for usb_rx_data_buffer.
// Expected values are hand-computed constants.
module tb_usb_rx_data_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        store;
  logic [7:0]  din;
  logic        flush;
  logic        get;
  logic [1:0]  dsz;
  logic [31:0] rx_data;
  logic        valid;
  logic [6:0]  occ;
  logic        ovf;
  logic        und;

  int total = 0;
  int bad   = 0;

  usb_rx_data_buffer dut (
    .clk                  (clk),
    .rst                  (rst),
    .store_rx_packet_data (store),
    .rx_packet_data       (din),
    .flush                (flush),
    .get_rx_data          (get),
    .data_size            (dsz),
    .rx_data              (rx_data),
    .rx_data_valid        (valid),
    .buffer_occupancy     (occ),
    .rx_overflow          (ovf),
    .rx_underrun          (und)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    store = 1'b1;
    din   = b;
    tick();
    store = 1'b0;
  endtask

  task automatic pop(input logic [1:0] s);
    get = 1'b1;
    dsz = s;
    tick();
    get = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; store = 1'b0; din = 8'h00;
    flush = 1'b0; get = 1'b0; dsz = 2'd0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_occ", 32'(occ), 32'd0);
    chk("rst_data", rx_data, 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_und", 32'(und), 32'd0);

    // four bytes, one word pop
    put(8'h11); chk("occ1", 32'(occ), 32'd1);
    put(8'h22); chk("occ2", 32'(occ), 32'd2);
    put(8'h33); chk("occ3", 32'(occ), 32'd3);
    put(8'h44); chk("occ4", 32'(occ), 32'd4);
    pop(2'd2);
    chk("w4_occ", 32'(occ), 32'd0);
    chk("w4_data", rx_data, 32'h44332211);
    chk("w4_valid", 32'(valid), 32'd1);
    tick();
    chk("w4_valid_off", 32'(valid), 32'd0);
    chk("w4_hold", rx_data, 32'h44332211);

    // underrun on short buffer
    put(8'hA1); put(8'hA2); put(8'hA3);
    pop(2'd2);
    chk("ur_flag", 32'(und), 32'd1);
    chk("ur_occ", 32'(occ), 32'd3);
    chk("ur_data", rx_data, 32'h44332211);
    chk("ur_valid", 32'(valid), 32'd0);
    pop(2'd1);
    chk("hw_data", rx_data, 32'h0000A2A1);
    chk("hw_occ", 32'(occ), 32'd1);
    chk("hw_valid", 32'(valid), 32'd1);
    pop(2'd3);
    chk("sz3_occ", 32'(occ), 32'd1);
    chk("sz3_valid", 32'(valid), 32'd0);
    chk("sz3_data", rx_data, 32'h0000A2A1);
    do_flush();
    chk("fl_occ", 32'(occ), 32'd0);
    chk("fl_und", 32'(und), 32'd0);
    chk("fl_data", rx_data, 32'd0);

    // fill and overflow
    for (int i = 0; i < 64; i++) put(8'(i));
    chk("full_occ", 32'(occ), 32'd64);
    chk("full_ovf0", 32'(ovf), 32'd0);
    put(8'h40);
    chk("ovf_occ", 32'(occ), 32'd64);
    chk("ovf_flag", 32'(ovf), 32'd1);
    for (int i = 0; i < 16; i++) begin
      pop(2'd2);
      chk($sformatf("drain%0d", i), rx_data,
          {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
    end
    chk("drain_occ", 32'(occ), 32'd0);
    chk("drain_ovf", 32'(ovf), 32'd1);

    // wrap-around read across 62,63,0,1
    for (int i = 0; i < 62; i++) put(8'(8'h80 + i));
    for (int i = 0; i < 62; i++) pop(2'd0);
    chk("wr_last", rx_data, 32'h000000BD);
    chk("wr_occ0", 32'(occ), 32'd0);
    put(8'hB0); put(8'hB1); put(8'hB2); put(8'hB3);
    pop(2'd2);
    chk("wr_data", rx_data, 32'hB3B2B1B0);
    chk("wr_occ", 32'(occ), 32'd0);

    // simultaneous store and pop
    put(8'hD1); put(8'hD2);
    store = 1'b1; din = 8'hC5;
    get = 1'b1; dsz = 2'd0;
    tick();
    store = 1'b0; get = 1'b0;
    chk("sim_occ", 32'(occ), 32'd2);
    chk("sim_data", rx_data, 32'h000000D1);
    pop(2'd0);
    chk("sim_p2", rx_data, 32'h000000D2);
    pop(2'd0);
    chk("sim_p3", rx_data, 32'h000000C5);
    chk("sim_occ0", 32'(occ), 32'd0);

    // flush beats store and pop
    do_flush();
    for (int i = 0; i < 65; i++) put(8'(i));
    for (int i = 0; i < 27; i++) pop(2'd1);
    chk("pf_occ", 32'(occ), 32'd10);
    chk("pf_ovf", 32'(ovf), 32'd1);
    flush = 1'b1; store = 1'b1; din = 8'hEE;
    get = 1'b1; dsz = 2'd0;
    tick();
    flush = 1'b0; store = 1'b0; get = 1'b0;
    chk("f_occ", 32'(occ), 32'd0);
    chk("f_ovf", 32'(ovf), 32'd0);
    chk("f_und", 32'(und), 32'd0);
    chk("f_data", rx_data, 32'd0);
    chk("f_valid", 32'(valid), 32'd0);

    // reset mid-sequence
    put(8'h5A); put(8'h5B);
    pop(2'd0);
    chk("pr_data", rx_data, 32'h0000005A);
    pop(2'd2);
    chk("pr_und", 32'(und), 32'd1);
    pop(2'd0);
    chk("pr_valid", 32'(valid), 32'd1);
    rst = 1'b1; store = 1'b1; din = 8'h77;
    get = 1'b1; dsz = 2'd0;
    tick();
    rst = 1'b0; store = 1'b0; get = 1'b0;
    chk("r_occ", 32'(occ), 32'd0);
    chk("r_data", rx_data, 32'd0);
    chk("r_valid", 32'(valid), 32'd0);
    chk("r_und", 32'(und), 32'd0);
    chk("r_ovf", 32'(ovf), 32'd0);
    put(8'h99);
    pop(2'd0);
    chk("r_after", rx_data, 32'h00000099);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
